// File: rtl/fft_mux_pkg.sv
// Shared types and helpers for the FFT mux/demux sequencer.
package fft_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned FFT_MUX_LATENCY = 3;
  localparam int unsigned BITREV_MAX_W    = 16;

  // Reverse the low w bits of a; bits at and above w come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] a,
                                                      input int unsigned w);
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) r[i] = a[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_sync_fifo.sv
// Synchronous FIFO with a registered head word: read data and empty come
// straight from flops and hold while the head is not popped.
module fft_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_wr,
  input  logic [WIDTH-1:0]               i_wdata,
  input  logic                           i_rd,
  output logic [WIDTH-1:0]               o_rdata,
  output logic                           o_empty,
  output logic                           o_full,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rdata;
  logic             r_empty;

  logic             w_rd;
  logic [AW-1:0]    w_rd_ptr_n;
  logic [CW-1:0]    w_count_n;
  logic [WIDTH-1:0] w_head_n;

  // Next head word: a write landing exactly on the new read slot bypasses the array.
  always_comb begin
    w_rd       = i_rd && !r_empty;
    w_rd_ptr_n = r_rd_ptr + AW'(w_rd);
    w_count_n  = r_count + CW'(i_wr) - CW'(w_rd);
    if (i_wr && (r_wr_ptr == w_rd_ptr_n)) w_head_n = i_wdata;
    else                                  w_head_n = r_mem[w_rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(i_wr);
      r_rd_ptr <= w_rd_ptr_n;
      r_count  <= w_count_n;
      r_rdata  <= w_head_n;
      r_empty  <= (w_count_n == '0);
    end
  end

  assign o_rdata = r_rdata;
  assign o_empty = r_empty;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/fft_mux_seq_ctrl.sv
// Frame sequencer for the pipelined FFT mux: issues sel in natural or
// bit-reversed order under FIFO credit control and streams the mux output.
module fft_mux_seq_ctrl
  import fft_mux_pkg::*;
#(
  parameter int unsigned N_LOG2     = 11,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LATENCY    = FFT_MUX_LATENCY,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  bitrev_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [N_LOG2-1:0]     sel_o,
  input  logic [DATA_WIDTH-1:0] mux_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);
  localparam int unsigned FW = DATA_WIDTH + 1;
  localparam logic [N_LOG2-1:0] CNT_LAST = '1;

  state_t              r_state, w_state_n;
  logic [N_LOG2-1:0]   r_cnt, w_cnt_n;
  logic [N_LOG2-1:0]   r_sel, w_sel_n;
  logic [N_LOG2-1:0]   w_cnt_rev;
  logic                r_bitrev, w_bitrev_n;
  logic                r_busy, w_busy_n;
  logic                r_done, w_done_n;
  logic                w_issue;
  logic                w_pop;
  logic [CW-1:0]       r_credits;
  // Bit 0 lines up with sel_o; bit LATENCY lines up with mux_data_i.
  logic [LATENCY:0]    r_vld_sr;
  logic [LATENCY:0]    r_last_sr;

  logic [FW-1:0]       w_fifo_rdata;
  logic                w_fifo_empty;
  logic                w_fifo_full;
  logic [CW-1:0]       w_fifo_count;

  assign w_cnt_rev = N_LOG2'(bitrev(BITREV_MAX_W'(r_cnt), N_LOG2));
  assign w_pop     = m_valid_o && m_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_bitrev <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_sel    <= w_sel_n;
      r_bitrev <= w_bitrev_n;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_sel_n    = r_sel;
    w_bitrev_n = r_bitrev;
    w_done_n   = 1'b0;
    w_issue    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_bitrev_n = bitrev_i;
          w_cnt_n    = '0;
          w_state_n  = RUN;
        end
      end
      RUN: begin
        if (r_credits != '0) begin
          w_issue = 1'b1;
          w_sel_n = r_bitrev ? w_cnt_rev : r_cnt;
          w_cnt_n = r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) w_state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && m_last_o) begin
          w_state_n = IDLE;
          w_done_n  = 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
    w_busy_n = (w_state_n != IDLE);
  end

  // Mux latency tracking and credit accounting; neither ever stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_sr  <= '0;
      r_last_sr <= '0;
      r_credits <= CW'(FIFO_DEPTH);
    end else begin
      r_vld_sr  <= {r_vld_sr[LATENCY-1:0], w_issue};
      r_last_sr <= {r_last_sr[LATENCY-1:0], w_issue && (r_cnt == CNT_LAST)};
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  fft_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (r_vld_sr[LATENCY]),
    .i_wdata ({r_last_sr[LATENCY], mux_data_i}),
    .i_rd    (m_ready_i),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign sel_o     = r_sel;
  assign m_data_o  = w_fifo_rdata[DATA_WIDTH-1:0];
  assign m_last_o  = w_fifo_rdata[DATA_WIDTH];
  assign m_valid_o = !w_fifo_empty;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(r_vld_sr[LATENCY] && w_fifo_full));

  // Every credit is either free, in flight through the mux, or parked in the FIFO.
  a_credit_conservation: assert property (@(posedge clk) disable iff (rst)
    (int'(r_credits) + int'(w_fifo_count) + $countones(r_vld_sr)) == int'(FIFO_DEPTH));

endmodule

// File: doc/fft_mux_seq_ctrl.md
# fft_mux_seq_ctrl

Sequencer for the 2048-point FFT mux/demux tree. It generates the `sel` stream for the 3-stage pipelined mux in natural or bit-reversed order and tracks the mux latency with a valid/last shift register. It captures the mux output into a small credit-protected FIFO and presents it downstream on a valid/ready stream. It sits between the FFT frame buffer, which feeds the mux `data_i`, and the output stream interface.

## Interface
Parameters:
- `N_LOG2`, 11: address width; frame length N = 2**N_LOG2.
- `DATA_WIDTH`, 8: mux data width.
- `LATENCY`, 3: mux pipeline depth in cycles, from `sel` to data.
- `FIFO_DEPTH`, 8: output FIFO entries. Must be a power of two and ≥ LATENCY+1. Full throughput is guaranteed when FIFO_DEPTH ≥ LATENCY+2.

Ports:
- `clk`  in  1  sole clock. Every flop is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  single-cycle request to read one frame. Sampled only in IDLE.
- `bitrev_i`  in  1  order select, sampled together with `start_i`. 0 = natural order, 1 = bit-reversed order.
- `busy_o`  out  1  high in RUN and DRAIN.
- `done_o`  out  1  one-cycle pulse after the last word has been accepted downstream.
- `sel_o`  out  N_LOG2  registered select, driven to the mux `sel`.
- `mux_data_i`  in  DATA_WIDTH  mux `data_o`.
- `m_data_o`  out  DATA_WIDTH  output stream data.
- `m_valid_o`  out  1  output stream valid.
- `m_ready_i`  in  1  output stream ready.
- `m_last_o`  out  1  high with the final word of a frame.

## Operation
- The FSM has three states: IDLE, RUN and DRAIN.
- **IDLE:**
  - On `start_i`, latch `bitrev_i`, clear the counter `cnt` and go to RUN.
- **RUN:**
  - An issue occurs in any cycle where `credits > 0`.
  - On issue:
    - `sel_o <= bitrev_i_latched ? reverse(cnt) : cnt`.
    - `cnt` increments.
    - Push 1 into the valid shift register (`vld_sr`), with last = (`cnt == N-1`).
  - Issuing with `cnt == N-1` moves the FSM to DRAIN.
- **DRAIN:**
  - No further issues.
  - Go to IDLE and pulse `done_o` in the cycle after the handshake (`m_valid_o & m_ready_i & m_last_o`).
- **Latency pipeline:**
  - `vld_sr` and `last_sr` are LATENCY deep and shift every cycle. They never stall, because the mux cannot stall.
  - A tap-LATENCY valid writes `{mux_data_i, last}` into the FIFO.
- **Credits:**
  - The credit counter resets to FIFO_DEPTH.
  - It decrements on issue and increments on pop (`m_valid_o & m_ready_i`). Issue and pop in the same cycle leave it unchanged.
  - The counter therefore guarantees a FIFO write never meets a full FIFO. Overflow is a design error and must be caught by an assertion.
- **FIFO:**
  - Registered output; `m_valid_o = !empty`.
  - Data and `m_last_o` hold stable while `m_valid_o & !m_ready_i`.
- `sel_o` holds its last value when no issue occurs.
- `start_i` outside IDLE is ignored.
- **Reset:** a reset at any point, including mid-frame, returns the block to:
  - IDLE.
  - `cnt` = 0, `sel_o` = 0.
  - `vld_sr` and `last_sr` cleared; FIFO emptied; credits = FIFO_DEPTH.
  - Partial frames are discarded.
- **Output reset values:** `busy_o`, `done_o`, `sel_o`, `m_data_o`, `m_valid_o` and `m_last_o` are all 0.

## Timing
- `start_i` is sampled at cycle 0.
- First `sel_o` at cycle 1.
- The word for a `sel_o` driven in cycle k is on `mux_data_i` in cycle k+LATENCY and is written into the FIFO at the end of that cycle.
- That word appears on `m_valid_o` at k+LATENCY+1 at the earliest. With the default LATENCY = 3 the first word is at cycle 5.
- With `m_ready_i` held high:
  - One word per cycle.
  - Last word at cycle N+4.
  - `done_o` at cycle N+5.
  - Back-to-back `start_i` is accepted at cycle N+6.
- **Credit round trip:** a pop in cycle t allows an issue in t+1, so the word for that issue arrives at the FIFO output at t+LATENCY+2.

## Structure
- **Package `fft_mux_pkg`:**
  - `state_t` enum {IDLE, RUN, DRAIN}.
  - Function `bitrev(logic [N_LOG2-1:0])`.
  - Constant `FFT_MUX_LATENCY = 3`.
- **Sub-module `fft_sync_fifo`:**
  - Parameterised by width and depth.
  - Ports: `clk`, `rst`, write, read, empty, full, count.
- The FSM, counters and shift register stay in the top module.

## Test plan
Bench model: DATA_WIDTH = 11, with the behavioural mux model returning `sel` delayed by 3 cycles.
- **Reset:** assert `rst` for 2 cycles → all outputs 0, credits = 8, `busy_o` = 0.
- **Natural order, `m_ready_i` held at 1:**
  - Words 0, 1, …, 2047.
  - First `m_valid_o` at cycle 5; `m_last_o` only on 2047 at cycle 2052.
  - `done_o` pulses at cycle 2053.
- **Bit-reversed order:**
  - Words begin 0, 1024, 512, 1536, 256.
  - Last word 2047.
  - Exactly 2048 words, each value seen once.
- **Backpressure:**
  - Hold `m_ready_i` = 0 for cycles 0–30 → exactly 8 issues, `m_valid_o` held with word 0, no overflow.
  - Then toggle `m_ready_i` randomly → the in-order sequence completes intact.
- **Ignored start:** pulse `start_i` with `bitrev_i` = 1 at cycle 100 of a natural-order frame → no effect; the order stays natural and a single `done_o` pulse occurs.
- **Reset mid-frame:**
  - `rst` at cycle 500 → next cycle IDLE, FIFO empty, `m_valid_o` = 0.
  - A new `start_i` then yields a full frame starting at word 0.
